// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports with write-through
// bypass, one synchronous write port, r0 hardwired to zero, per-register pending bits.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  busy_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy_b,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  alloc_en,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_live;
    logic                  alloc_live;

    assign wr_live    = wr_en && (wr_addr != '0);
    assign alloc_live = alloc_en && (alloc_addr != '0);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_live && (wr_addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Alloc is applied after the write-back clear so a colliding new producer wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_live) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (alloc_live) begin
            pending_d[alloc_addr] = 1'b1;
        end
        count_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            count_d = count_d + (ADDR_WIDTH + 1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
        end
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
        end
    end

    // pending_q[0] is never set, so address 0 reads as not busy.
    assign busy_a = pending_q[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
    assign busy_b = pending_q[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));

    assign pending_count = count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset sweep, r0, bypass, scoreboard.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, alloc_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        busy_a, busy_b, wr_en, alloc_en;
    logic [5:0]  pending_count;

    int total = 0;
    int bad   = 0;

    reg_file dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; alloc_en = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; alloc_addr = '0; wr_data = '0;
        #1;
        chk("init_count", 32'(pending_count), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // write reg5 and alloc 12, then reset mid-run
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        alloc_en = 1'b1; alloc_addr = 5'd12;
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd12;
        #1;
        chk("pre_rst_r5", rd_data_a, 32'hDEADBEEF);
        chk("pre_rst_busy12", 32'(busy_b), 32'd1);
        chk("pre_rst_count", 32'(pending_count), 32'd1);

        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(pending_count), 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #0.1;
            chk($sformatf("rst_data_%0d", i), rd_data_a, 32'd0);
            chk($sformatf("rst_busy_%0d", i), 32'(busy_a), 32'd0);
        end
        tick();
        reset = 1'b0;

        // write reg7 and attempt to write r0
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        tick();
        wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 5'd7; rd_addr_b = 5'd0;
        #1;
        chk("r7", rd_data_a, 32'h12345678);
        chk("r0", rd_data_b, 32'h00000000);
        chk("nonpend_count", 32'(pending_count), 32'd0);

        // bypass on both ports
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000001;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 5'd9; rd_addr_b = 5'd9;
        #1;
        chk("r9_old", rd_data_a, 32'h00000001);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        #1;
        chk("byp_a", rd_data_a, 32'hA5A5A5A5);
        chk("byp_b", rd_data_b, 32'hA5A5A5A5);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r9_stored", rd_data_a, 32'hA5A5A5A5);

        // scoreboard set / clear
        alloc_en = 1'b1; alloc_addr = 5'd3;
        tick();
        alloc_addr = 5'd4;
        tick();
        alloc_en = 1'b0;
        rd_addr_a = 5'd3; rd_addr_b = 5'd4;
        #1;
        chk("sb_count2", 32'(pending_count), 32'd2);
        chk("sb_busy3", 32'(busy_a), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000033;
        #1;
        chk("sb_busy3_wr", 32'(busy_a), 32'd0);
        chk("sb_byp3", rd_data_a, 32'h00000033);
        chk("sb_busy4_wr", 32'(busy_b), 32'd1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("sb_count1", 32'(pending_count), 32'd1);
        chk("sb_busy3_after", 32'(busy_a), 32'd0);
        chk("sb_busy4_after", 32'(busy_b), 32'd1);

        // alloc/write collision on reg6
        alloc_en = 1'b1; alloc_addr = 5'd6;
        tick();
        alloc_en = 1'b0;
        #1;
        chk("col_count_pre", 32'(pending_count), 32'd2);
        alloc_en = 1'b1; alloc_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h00000055;
        tick();
        alloc_en = 1'b0; wr_en = 1'b0;
        rd_addr_a = 5'd6;
        #1;
        chk("col_data", rd_data_a, 32'h00000055);
        chk("col_busy", 32'(busy_a), 32'd1);
        chk("col_count", 32'(pending_count), 32'd2);

        // fresh start: alloc r0, then duplicate alloc of reg10
        reset = 1'b1;
        tick();
        reset = 1'b0;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        tick();
        rd_addr_a = 5'd0;
        #1;
        chk("a0_busy", 32'(busy_a), 32'd0);
        chk("a0_count", 32'(pending_count), 32'd0);
        alloc_addr = 5'd10;
        tick();
        tick();
        alloc_en = 1'b0;
        rd_addr_b = 5'd10;
        #1;
        chk("dup_count", 32'(pending_count), 32'd1);
        chk("dup_busy0", 32'(busy_a), 32'd0);
        chk("dup_busy10", 32'(busy_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
General-purpose register file for the processor datapath. It is built from an array of 32-bit register stages. It provides two combinational read ports, one synchronous write port with same-cycle write-through bypass, and r0 hardwired to zero. It also keeps a per-register pending (scoreboard) bit. Issue logic uses this bit to detect reads of registers that an in-flight instruction has not yet written back.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (32)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers and pending bits
rd_addr_a  input  ADDR_WIDTH  read port A index
rd_data_a  output  DATA_WIDTH  read port A data (combinational)
busy_a  output  1  register at rd_addr_a is pending (combinational)
rd_addr_b  input  ADDR_WIDTH  read port B index
rd_data_b  output  DATA_WIDTH  read port B data (combinational)
busy_b  output  1  register at rd_addr_b is pending (combinational)
wr_en  input  1  write-back strobe
wr_addr  input  ADDR_WIDTH  write-back index
wr_data  input  DATA_WIDTH  write-back data
alloc_en  input  1  issue strobe: mark alloc_addr pending
alloc_addr  input  ADDR_WIDTH  destination index of issuing instruction
pending_count  output  ADDR_WIDTH+1  number of registers currently pending (registered)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high, all NUM_REGS registers = 0, all pending bits = 0, pending_count = 0. Reset asserted mid-operation discards any in-flight write or alloc in that cycle.
- Reset-derived outputs: after reset, rd_data_a/b = 0 and busy_a/b = 0 for every address.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. The update is visible through storage on the next cycle.
- r0: writes to address 0 are ignored and reading address 0 always returns 0.
- Read: rd_data_x = reg[rd_addr_x], with zero latency.
- Bypass: if wr_en=1, wr_addr==rd_addr_x and wr_addr!=0 in the same cycle, rd_data_x = wr_data (write-first). Ports A and B are independent; both may bypass at once.
- Pending set: on a rising edge with alloc_en=1 and alloc_addr!=0, pending[alloc_addr] <= 1. alloc to r0 is ignored; r0 is never pending.
- Pending clear: on a rising edge with wr_en=1 and wr_addr!=0, pending[wr_addr] <= 0.
- Simultaneous alloc and write to the same non-zero address: the data write happens and pending ends at 1 (new producer wins).
- Alloc to an already-pending register: the bit stays 1; there is no count change and no error.
- Write to a non-pending register: the data write happens and pending stays 0.
- busy_x = pending[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x). The same-cycle write-back clears the hazard together with the data bypass. busy_x = 0 for address 0.
- pending_count: registered population count of the pending bits, reflecting the post-edge state. It stays within 0..NUM_REGS-1.
- Storage: the storage array is an array of register stages with per-register write enable = wr_en AND decode(wr_addr) AND wr_addr!=0, extended with asynchronous reset.

Test Plan:
- Reset then sweep reads: assert reset mid-run after writing reg5=0xDEADBEEF. Required: rd_data_a=0 for addresses 0..31, busy_a=0, pending_count=0 immediately, before any clock edge.
- Write/read and r0: write reg7=0x12345678 and reg0=0xFFFFFFFF. Next cycle rd_addr_a=7 -> 0x12345678; rd_addr_b=0 -> 0x00000000.
- Bypass: in a single cycle, wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5, rd_addr_a=rd_addr_b=9 (reg9 previously 0x1). Required: both ports = 0xA5A5A5A5 in that same cycle.
- Scoreboard: alloc 3 then alloc 4 on consecutive edges. Required: pending_count=2, busy_a=1 at addr 3. Then write 3 -> busy_a drops combinationally in the write cycle and pending_count=1 after the edge.
- Alloc/write collision: with reg6 pending, in one cycle alloc_en=1, alloc_addr=6, wr_en=1, wr_addr=6, wr_data=0x55. Required: after the edge reg6=0x55, busy at 6 = 1, pending_count unchanged.
- Alloc r0 and duplicate alloc: alloc 0, then alloc 10 twice. Required: busy at 0 stays 0 and pending_count=1.
